// File: rtl/sobolrng_ctrl_pkg.sv
// Shared types and constants for the Sobol RNG sequencing controller.
package sobolrng_ctrl_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All-ones step index for a counter of width w (w <= 63).
    // Used as the final step index when no run length is supplied.
    function automatic logic [63:0] last_all_ones(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sobolrng_ctrl_lsz_onehot.sv
// Lowest-zero-bit one-hot encoder.
// Output bit i is set where i is the lowest index with iVal[i] == 0.
// An all-ones input yields an all-zero output, so the core XORs nothing.
module lsz_onehot #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] iVal,
    output logic [BITWIDTH-1:0] oOneHot
);

    // Adding one carries through the trailing ones and lands on the lowest
    // zero; masking with ~iVal keeps only that bit. All ones wraps to zero.
    assign oOneHot = ~iVal & (iVal + 1'b1);

endmodule

// File: rtl/sobolrng_ctrl.sv
// Sequencing controller in front of the Sobol RNG core.
// Issues a clear pulse, then one enable per step carrying the lowest-zero
// one-hot of the step counter. All outputs are registered.
//
// Optional feature: define SOBOLRNG_CTRL_RUNLEN_EN to add the iLen port,
// which sets the final step index (iLen+1 steps). Without it a run covers
// every counter value (2^BITWIDTH steps).
//
// state | meaning
// IDLE  | waiting for iStart
// CLR   | oClr pulse out; first step may issue on the exit edge
// RUN   | issuing steps, one per unheld cycle
// DONE  | oDone pulse out, then back to IDLE
module sobolrng_ctrl
    import sobolrng_ctrl_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iHold,
    input  logic                iAbort,
`ifdef SOBOLRNG_CTRL_RUNLEN_EN
    input  logic [BITWIDTH-1:0] iLen,
`endif
    output logic                oBusy,
    output logic                oClr,
    output logic                oEn,
    output logic [BITWIDTH-1:0] oOneHot,
    output logic [BITWIDTH-1:0] oCnt,
    output logic                oLast,
    output logic                oDone
);

    localparam logic [BITWIDTH-1:0] LAST_DEF = BITWIDTH'(last_all_ones(BITWIDTH));

    state_t              r_state;
    logic [BITWIDTH-1:0] r_cnt;
    logic                r_busy;
    logic                r_clr;
    logic                r_en;
    logic [BITWIDTH-1:0] r_onehot;
    logic [BITWIDTH-1:0] r_cnt_out;
    logic                r_last;
    logic                r_done;

    logic [BITWIDTH-1:0] w_onehot;
    logic [BITWIDTH-1:0] w_last_idx;
    logic                w_is_last;

`ifdef SOBOLRNG_CTRL_RUNLEN_EN
    logic [BITWIDTH-1:0] r_last_idx;

    // Capture the requested run length with the accepted start.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_last_idx <= '0;
        end else if (r_state == ST_IDLE && iStart && !iAbort) begin
            r_last_idx <= iLen;
        end
    end

    assign w_last_idx = r_last_idx;
`else
    assign w_last_idx = LAST_DEF;
`endif

    assign w_is_last = (r_cnt == w_last_idx);

    lsz_onehot #(
        .BITWIDTH (BITWIDTH)
    ) u_lsz (
        .iVal    (r_cnt),
        .oOneHot (w_onehot)
    );

    // Controller FSM, step counter and all output registers.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_clr     <= 1'b0;
            r_en      <= 1'b0;
            r_onehot  <= '0;
            r_cnt_out <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_clr     <= 1'b0;
            r_en      <= 1'b0;
            r_onehot  <= '0;
            r_cnt_out <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            if (iAbort) begin
                // Abort beats everything, including a start in IDLE.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                        if (iStart) begin
                            r_state <= ST_CLR;
                            r_clr   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    ST_CLR, ST_RUN: begin
                        // The first step leaves on the CLR exit edge so it
                        // lands one cycle after the clear pulse.
                        r_busy <= 1'b1;
                        if (r_state == ST_CLR) begin
                            r_state <= ST_RUN;
                        end
                        if (!iHold) begin
                            r_en      <= 1'b1;
                            r_onehot  <= w_onehot;
                            r_cnt_out <= r_cnt;
                            r_last    <= w_is_last;
                            // Counter stops on the last index; it never wraps
                            // inside a run.
                            if (w_is_last) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oBusy   = r_busy;
    assign oClr    = r_clr;
    assign oEn     = r_en;
    assign oOneHot = r_onehot;
    assign oCnt    = r_cnt_out;
    assign oLast   = r_last;
    assign oDone   = r_done;

endmodule
